// File: rtl/nic_access_scheduler.sv
// Arbitrates a one-byte transmit slot and NIC receive reads onto a single NIC
// access port, with round-robin fairness and a per-access ack timeout.
module nic_access_scheduler #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_accept,
  input  logic       rx_avail,
  input  logic       nic_ack,
  input  logic [7:0] nic_rdata,
  output logic       nic_write,
  output logic       nic_read,
  output logic [7:0] nic_wdata,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       timeout_err,
  output logic [3:0] tx_count,
  output logic [3:0] rx_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t     state_q;
  logic       slot_full_q;
  logic [7:0] slot_data_q;
  logic       prefer_read_q;
  logic [7:0] wait_q;

  logic       capture_d;
  logic       grant_write_d;
  logic       grant_read_d;
  logic       wait_expired_d;

  // The slot only reloads when it was already empty before the edge, so a
  // freed slot is refilled no earlier than the following edge.
  always_comb begin
    capture_d      = tx_req && !slot_full_q;
    grant_write_d  = slot_full_q && (!rx_avail || !prefer_read_q);
    grant_read_d   = rx_avail && (!slot_full_q || prefer_read_q);
    wait_expired_d = (wait_q == 8'(WAIT_TIMEOUT - 1));
  end

  assign nic_wdata = slot_data_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_full_q   <= 1'b0;
      slot_data_q   <= 8'h00;
      prefer_read_q <= 1'b1;
      wait_q        <= 8'h00;
      tx_accept     <= 1'b0;
      nic_write     <= 1'b0;
      nic_read      <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      timeout_err   <= 1'b0;
      tx_count      <= 4'h0;
      rx_count      <= 4'h0;
    end else begin
      tx_accept   <= capture_d;
      rx_valid    <= 1'b0;
      timeout_err <= 1'b0;
      if (capture_d) begin
        slot_full_q <= 1'b1;
        slot_data_q <= tx_data;
      end
      case (state_q)
        IDLE: begin
          wait_q <= 8'h00;
          if (grant_write_d) begin
            state_q       <= WRITE;
            nic_write     <= 1'b1;
            prefer_read_q <= 1'b1;
          end else if (grant_read_d) begin
            state_q       <= READ;
            nic_read      <= 1'b1;
            prefer_read_q <= 1'b0;
          end
        end
        WRITE: begin
          // Ack wins over a timeout landing on the same edge.
          if (nic_ack) begin
            state_q     <= IDLE;
            nic_write   <= 1'b0;
            slot_full_q <= 1'b0;
            tx_count    <= tx_count + 4'd1;
          end else if (wait_expired_d) begin
            state_q     <= IDLE;
            nic_write   <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        READ: begin
          if (nic_ack) begin
            state_q  <= IDLE;
            nic_read <= 1'b0;
            rx_data  <= nic_rdata;
            rx_valid <= 1'b1;
            rx_count <= rx_count + 4'd1;
          end else if (wait_expired_d) begin
            state_q     <= IDLE;
            nic_read    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          nic_write <= 1'b0;
          nic_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule
